// File: rtl/freq_list_stream.sv
// freq_list_stream: counts a valid/ready symbol stream into a histogram, then
// streams packed freq_list entries out on a valid/ready port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_CLEAR | zeroing bins NUM_SYMS-1 down to 0, one per cycle
// S_COUNT | accepting symbols into the read-modify-write pipe
// S_DRAIN | one cycle for the final increment to land in the RAM
// S_DUMP  | walking indices 0..LIST_DEPTH-1 and presenting entries
// S_DONE  | histogram retained, waiting for the next start
module freq_list_stream #(
  parameter int SYM_W      = 9,
  parameter int NUM_SYMS   = 286,
  parameter int FREQ_W     = 12,
  parameter int LIST_W     = 63,
  parameter int LIST_DEPTH = 573,
  parameter bit SKIP_ZERO  = 1'b0,
  parameter int IDX_W      = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              sym_valid_i,
  output logic              sym_ready_o,
  input  logic [SYM_W-1:0]  sym_data_i,
  input  logic              sym_last_i,
  output logic              fl_valid_o,
  input  logic              fl_ready_i,
  output logic [LIST_W-1:0] fl_data_o,
  output logic [IDX_W-1:0]  fl_index_o,
  output logic              fl_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              bad_symbol_o,
  output logic [IDX_W-1:0]  nz_count_o
);
  localparam int                LOW_W    = LIST_W - SYM_W - FREQ_W;
  localparam logic [FREQ_W-1:0] FMAX     = {FREQ_W{1'b1}};
  localparam logic [IDX_W-1:0]  NSYM     = IDX_W'(NUM_SYMS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LIST_DEPTH - 1);
  localparam logic [SYM_W-1:0]  CLR_TOP  = SYM_W'(NUM_SYMS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COUNT, S_DRAIN, S_DUMP, S_DONE} state_e;
  state_e state_q, state_d;

  logic [FREQ_W-1:0] mem_q [NUM_SYMS];
  logic [FREQ_W-1:0] rdata_q;
  logic [SYM_W-1:0]  clr_cnt_q;
  logic              s1_v_q, wr_v_q;
  logic [SYM_W-1:0]  s1_sym_q, wr_sym_q;
  logic [FREQ_W-1:0] wr_val_q;
  logic [IDX_W-1:0]  fet_idx_q, r_idx_q, fl_idx_q, nz_q, nz_seen_q;
  logic              fet_end_q, r_v_q, r_zero_q;
  logic              fl_valid_q, fl_last_q;
  logic [LIST_W-1:0] fl_data_q;
  logic              ovf_q, bad_q, done_q;

  logic              acc, sym_ok, sat, o_free, load, keep, issue, r_last, take_last;
  logic [FREQ_W-1:0] s1_old, s1_new, r_freq;

  // Pipe forwarding, saturating increment and dump handshake decisions.
  always_comb begin
    acc       = (state_q == S_COUNT) && sym_valid_i;
    sym_ok    = IDX_W'(sym_data_i) < NSYM;
    // The RAM read of a symbol accepted right after the same symbol misses the
    // write that lands on the same edge, so take the value from the write stage.
    s1_old    = (wr_v_q && (wr_sym_q == s1_sym_q)) ? wr_val_q : rdata_q;
    sat       = (s1_old == FMAX);
    s1_new    = sat ? s1_old : s1_old + 1'b1;
    r_freq    = r_zero_q ? '0 : rdata_q;
    o_free    = !fl_valid_q || fl_ready_i;
    load      = (state_q == S_DUMP) && r_v_q && o_free;
    keep      = load && (!SKIP_ZERO || (r_freq != '0));
    issue     = (state_q == S_DUMP) && !fet_end_q && (!r_v_q || o_free);
    r_last    = SKIP_ZERO ? ((nz_seen_q + 1'b1) == nz_q) : (r_idx_q == LAST_IDX);
    take_last = fl_valid_q && fl_ready_i && fl_last_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_CLEAR;
      S_CLEAR:        if (clr_cnt_q == '0) state_d = S_COUNT;
      S_COUNT:        if (acc && sym_last_i) state_d = S_DRAIN;
      S_DRAIN:        state_d = S_DUMP;
      S_DUMP:         if ((SKIP_ZERO && (nz_q == '0)) || take_last) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Histogram RAM: clear/increment write port and one registered read port.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) mem_q[clr_cnt_q] <= '0;
    else if (s1_v_q)        mem_q[s1_sym_q]  <= s1_new;
    if (acc && sym_ok)                     rdata_q <= mem_q[sym_data_i];
    else if (issue && (fet_idx_q < NSYM))  rdata_q <= mem_q[fet_idx_q[SYM_W-1:0]];
  end

  // Count pipe, status flags, dump fetch stage and output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_cnt_q  <= '0;
      s1_v_q     <= 1'b0;
      s1_sym_q   <= '0;
      wr_v_q     <= 1'b0;
      wr_sym_q   <= '0;
      wr_val_q   <= '0;
      fet_idx_q  <= '0;
      fet_end_q  <= 1'b0;
      r_v_q      <= 1'b0;
      r_zero_q   <= 1'b0;
      r_idx_q    <= '0;
      fl_valid_q <= 1'b0;
      fl_last_q  <= 1'b0;
      fl_data_q  <= '0;
      fl_idx_q   <= '0;
      nz_q       <= '0;
      nz_seen_q  <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_d == S_DONE) && (state_q != S_DONE);
      s1_v_q <= acc && sym_ok;
      if (acc) s1_sym_q <= sym_data_i;
      wr_v_q <= s1_v_q;
      if (s1_v_q) begin
        wr_sym_q <= s1_sym_q;
        wr_val_q <= s1_new;
        if (sat)            ovf_q <= 1'b1;
        if (s1_old == '0)   nz_q  <= nz_q + 1'b1;
      end
      if (acc && !sym_ok) bad_q <= 1'b1;

      if (issue) begin
        r_v_q     <= 1'b1;
        r_idx_q   <= fet_idx_q;
        r_zero_q  <= (fet_idx_q >= NSYM);
        fet_idx_q <= fet_idx_q + 1'b1;
        if (fet_idx_q == LAST_IDX) fet_end_q <= 1'b1;
      end else if (load) begin
        r_v_q <= 1'b0;
      end
      if (o_free) begin
        fl_valid_q <= keep;
        if (keep) begin
          fl_data_q <= {r_idx_q[SYM_W-1:0], r_freq, {LOW_W{1'b0}}};
          fl_idx_q  <= r_idx_q;
          fl_last_q <= r_last;
          nz_seen_q <= nz_seen_q + 1'b1;
        end
      end

      if (state_q == S_CLEAR) begin
        clr_cnt_q  <= clr_cnt_q - 1'b1;
        wr_v_q     <= 1'b0;
        nz_q       <= '0;
        nz_seen_q  <= '0;
        ovf_q      <= 1'b0;
        bad_q      <= 1'b0;
        fet_idx_q  <= '0;
        fet_end_q  <= 1'b0;
        r_v_q      <= 1'b0;
        fl_valid_q <= 1'b0;
      end else begin
        clr_cnt_q <= CLR_TOP;
      end
    end
  end

  assign sym_ready_o  = (state_q == S_COUNT);
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign bad_symbol_o = bad_q;
  assign nz_count_o   = nz_q;
  assign fl_valid_o   = fl_valid_q;
  assign fl_data_o    = fl_data_q;
  assign fl_index_o   = fl_idx_q;
  assign fl_last_o    = fl_last_q;
endmodule
